uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8N1 UART transmitter: the transmit-side counterpart of the existing mid-bit-sampling receive path and its baud counter.
- Accepts one byte per valid/ready handshake and serialises it LSB first on tx as start (0), 8 data bits, stop (1).
- Each bit is held for exactly BPS_T+1 clock cycles.
- Sits between the command/response logic and the board TX pin.

Parameters:
- BPS_T, 5207, bit period minus one in clk cycles (50 MHz / 9600 baud); legal range 1..8191.
- CNT_W, 13, bit-period counter width; must satisfy 2^CNT_W > BPS_T.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- tx_data  input  8  byte to send; sampled only on handshake
- tx_valid  input  1  tx_data holds a byte to send
- tx_ready  output  1  block can accept a byte this cycle (high only in IDLE)
- tx  output  1  serial line, registered, idle high
- tx_busy  output  1  frame in progress (inverse of tx_ready)

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE, bit counter=0, bit index=0, shift register=0.
  - Outputs: tx=1, tx_ready=1, tx_busy=0.
  - Reset takes priority over every other event, including mid-frame; the line returns high on the next edge with no partial stop bit.
- States:
  - IDLE -> START when tx_valid && tx_ready at an edge. tx_data is latched into the shift register, and tx=0 from that edge.
  - START: hold tx=0 for BPS_T+1 cycles, then go to DATA with tx=shift[0] and bit index=0.
  - DATA: each bit is held BPS_T+1 cycles. At the end of each bit, shift right and increment the index. After index 7 completes, go to STOP with tx=1.
  - STOP: hold tx=1 for BPS_T+1 cycles, then go to IDLE.
- Bit counter:
  - Counts 0..BPS_T while state != IDLE.
  - Wraps to 0 at BPS_T; that wrap is the bit-advance tick.
  - Forced to 0 in IDLE.
  - No other wrap path.
- Frame timing:
  - From the accepting edge, tx is low for exactly BPS_T+1 cycles.
  - Total frame is 10*(BPS_T+1) cycles.
  - tx_ready rises on the edge that ends STOP.
- Back-to-back: with tx_valid held high, the next byte is accepted in the first IDLE cycle. The next start bit therefore begins 10*(BPS_T+1)+1 cycles after the previous one (one extra idle-high cycle).
- Ignored inputs:
  - tx_valid while busy is ignored; nothing is queued and no byte is dropped silently on the block's side, because the handshake does not complete.
  - tx_data changes after the accepting edge have no effect on the current frame.
- tx changes only on bit-advance edges or the accepting edge, so the line is glitch-free.
- tx_ready and tx_busy are decoded from the state register only and never depend combinationally on tx_valid.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_BITS=8
  - UART_FRAME_BITS=10
  - UART_BPS_T_9600=13'd5207
  - the state enum typedef {IDLE, START, DATA, STOP}, reused by receive-side rework.
- One natural sub-module: uart_tx_bps.
  - Enable-driven bit-period counter: input enable, output tick at count==BPS_T.
  - Sync reset.
  - The transmit-side sibling of the receive baud counter.
- The FSM and shift register stay in uart_tx.

Test Plan:
All scenarios use BPS_T=7 (8 cycles/bit).
- Reset: hold rst 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0 throughout; no handshake occurs.
- Single byte 0x55: one-cycle tx_valid -> tx reads 0,1,0,1,0,1,0,1,0,1, each exactly 8 cycles. tx_ready is low exactly 80 cycles, then high.
- Byte 0xA3 with a mid-bit sampling monitor (samples at count 4) -> data bits 1,1,0,0,0,1,0,1 are observed and reconstruct 0xA3; stop bit = 1.
- Back-to-back 0x00 then 0xFF with tx_valid held:
  - Second start-bit falling edge lands exactly 81 cycles after the first.
  - Exactly 1 idle-high cycle sits between the frames.
  - Second frame reads 0,1×8,1.
- Busy interference: during the 0x3C frame, pulse tx_valid with 0x12 and toggle tx_data every cycle -> the waveform is still 0x3C, and 0x12 is never transmitted.
- Mid-frame reset: assert rst for 1 cycle during data bit 3 of 0xF0 -> tx=1 and tx_ready=1 on the next edge. A subsequent 0x81 is then sent cleanly: 0,1,0,0,0,0,0,0,1,1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor and the
// state encoding used by both the transmit and receive paths.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    // 50 MHz / 9600 baud, minus one.
    localparam logic [12:0] UART_BPS_T_9600 = 13'd5207;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_bps.sv
// Bit-period counter for the transmitter: counts 0..BPS_T while enabled,
// pulses tick on the final count and wraps; held at zero when disabled.
module uart_tx_bps #(
    parameter int unsigned BPS_T = 5207,
    parameter int unsigned CNT_W = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BPS_T);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_top;

    assign at_top = (cnt_q == CNT_TOP);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (at_top) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && at_top;

endmodule : uart_tx_bps

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte input, serialised LSB first as
// start(0), 8 data bits, stop(1), each bit held BPS_T+1 clocks.
import uart_pkg::*;

module uart_tx #(
    parameter int unsigned BPS_T = 32'(UART_BPS_T_9600),
    parameter int unsigned CNT_W = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_state_e state_q;
    uart_state_e state_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic        tx_q;
    logic        tx_d;
    logic        bit_tick;
    logic        cnt_en;

    assign cnt_en = (state_q != IDLE);

    uart_tx_bps #(
        .BPS_T (BPS_T),
        .CNT_W (CNT_W)
    ) u_bps (
        .clk    (clk),
        .rst    (rst),
        .en_i   (cnt_en),
        .tick_o (bit_tick)
    );

    // tx_d is only ever changed on the accepting edge or a bit tick,
    // so the registered line never glitches between bits.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    idx_d   = 3'd0;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BPS_T=7 (8 clocks per bit); inputs driven
// and outputs sampled on the falling edge.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    uart_tx #(
        .BPS_T (7),
        .CNT_W (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walks one frame from its first START cycle, checking {tx,ready,busy}
    // every cycle and sampling data/stop at cycle 4 of each bit. With mess
    // set, tx_valid is pulsed with junk data while the frame is busy.
    task automatic check_frame(input string tag, input logic [9:0] exp, input bit mess,
                               output logic [7:0] rx, output logic stop_s);
        rx     = 'x;
        stop_s = 1'bx;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("%s bit%0d cyc%0d", tag, i, j),
                    {29'd0, tx, tx_ready, tx_busy}, {29'd0, exp[i], 2'b01});
                if (j == 4 && i >= 1 && i <= 8) rx[i-1] = tx;
                if (j == 4 && i == 9) stop_s = tx;
                if (mess) begin
                    tx_data  = j[0] ? 8'h12 : 8'hED;
                    tx_valid = (i == 3 || i == 4);
                end
                @(negedge clk);
            end
        end
        chk({tag, " end idle"}, {29'd0, tx, tx_ready, tx_busy}, 32'b110);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    logic [7:0] rx;
    logic       stop_s;
    int         t0;
    int         t1;

    initial begin
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;

        // Reset held 3 cycles with tx_valid high: no handshake.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("reset cyc%0d", k), {29'd0, tx, tx_ready, tx_busy}, 32'b110);
        end
        rst      = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        chk("post reset idle", {29'd0, tx, tx_ready, tx_busy}, 32'b110);

        // 0x55: alternating line, ready low exactly 80 cycles.
        send(8'h55);
        check_frame("f55", 10'b1010101010, 1'b0, rx, stop_s);
        chk("f55 rx", {24'd0, rx}, 32'h55);
        $display("tx byte 0x55 observed 0x%02h", rx);

        // 0xA3 with mid-bit sampling.
        send(8'hA3);
        check_frame("fA3", 10'b1101000110, 1'b0, rx, stop_s);
        chk("fA3 rx", {24'd0, rx}, 32'hA3);
        chk("fA3 stop", {31'd0, stop_s}, 32'd1);
        $display("tx byte 0xA3 observed 0x%02h stop %0b", rx, stop_s);

        // Back-to-back 0x00 then 0xFF with tx_valid held.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        t0      = cyc;
        tx_data = 8'hFF;
        check_frame("f00", 10'b1000000000, 1'b0, rx, stop_s);
        chk("f00 rx", {24'd0, rx}, 32'h00);
        $display("tx byte 0x00 observed 0x%02h", rx);
        @(negedge clk);
        t1       = cyc;
        tx_valid = 1'b0;
        chk("b2b start spacing", t1 - t0, 32'd81);
        check_frame("fFF", 10'b1111111110, 1'b0, rx, stop_s);
        chk("fFF rx", {24'd0, rx}, 32'hFF);
        $display("tx byte 0xFF observed 0x%02h spacing %0d", rx, t1 - t0);

        // Busy interference during 0x3C.
        send(8'h3C);
        check_frame("f3C", 10'b1001111000, 1'b1, rx, stop_s);
        chk("f3C rx", {24'd0, rx}, 32'h3C);
        tx_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("no 0x12 frame cyc%0d", k), {29'd0, tx, tx_ready, tx_busy}, 32'b110);
        end
        $display("tx byte 0x3C observed 0x%02h with interference", rx);

        // Mid-frame reset during data bit 3 of 0xF0.
        send(8'hF0);
        for (int k = 0; k < 35; k++) @(negedge clk);
        chk("fF0 in bit3", {29'd0, tx, tx_ready, tx_busy}, 32'b001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midframe reset", {29'd0, tx, tx_ready, tx_busy}, 32'b110);
        $display("tx byte 0xF0 aborted by reset");
        @(negedge clk);
        send(8'h81);
        check_frame("f81", 10'b1100000010, 1'b0, rx, stop_s);
        chk("f81 rx", {24'd0, rx}, 32'h81);
        $display("tx byte 0x81 observed 0x%02h", rx);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx
